rv32_step_sequencer: RTL and testbench

//  Control FSM that sequences the multi-cycle RV32I core datapath:

---
 rtl/rv32_step_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_rv32_step_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_step_sequencer.sv
// rv32_step_sequencer: control FSM for a multi-cycle RV32I datapath.
// Sequences fetch, register read, execute and the load/store memory phases.
// Handles wait-state memory with a bounded timeout and halt/resume on SYSTEM
// instructions, and counts retired instructions.
module rv32_step_sequencer #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_system,
    input  logic             writes_rd,
    input  logic             mem_rbusy,
    input  logic             mem_wbusy,
    input  logic             resume,
    output logic             mem_rstrb,
    output logic             mem_wstrb,
    output logic             mem_addr_sel,
    output logic             instr_we,
    output logic             regs_en,
    output logic             wb_en,
    output logic             wb_sel_load,
    output logic             pc_en,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_FETCH_INSTR = 3'd0,
        S_WAIT_INSTR  = 3'd1,
        S_FETCH_REGS  = 3'd2,
        S_EXECUTE     = 3'd3,
        S_LOAD        = 3'd4,
        S_WAIT_DATA   = 3'd5,
        S_STORE       = 3'd6,
        S_WAIT_STORE  = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;

    // While halted the sequencer parks in FETCH_INSTR, so state reads 0.
    assign state   = state_q;
    assign halted  = halted_q;
    assign fault   = fault_q;
    assign instret = instret_q;

    // Next-state, counter updates and strobe/enable decode.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        halted_d     = halted_q;
        fault_d      = fault_q;
        instret_d    = instret_q;
        wait_cnt_d   = '0;       // clears outside WAIT_* and on entry to one
        mem_rstrb    = 1'b0;
        mem_wstrb    = 1'b0;
        mem_addr_sel = 1'b0;
        instr_we     = 1'b0;
        regs_en      = 1'b0;
        wb_en        = 1'b0;
        wb_sel_load  = 1'b0;
        pc_en        = 1'b0;

        if (halted_q) begin
            if (resume) begin
                halted_d = 1'b0;
                fault_d  = 1'b0;
                pc_en    = 1'b1;
                state_d  = S_FETCH_INSTR;
            end
        end else begin
            unique case (state_q)
                S_FETCH_INSTR: begin
                    mem_rstrb = 1'b1;
                    state_d   = S_WAIT_INSTR;
                end
                S_WAIT_INSTR: begin
                    if (!mem_rbusy) begin
                        instr_we = 1'b1;
                        state_d  = S_FETCH_REGS;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        halted_d = 1'b1;
                        fault_d  = 1'b1;
                        state_d  = S_FETCH_INSTR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                S_FETCH_REGS: begin
                    regs_en = 1'b1;
                    state_d = S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (is_load) begin
                        pc_en   = 1'b1;
                        state_d = S_LOAD;
                    end else if (is_store) begin
                        pc_en   = 1'b1;
                        state_d = S_STORE;
                    end else if (is_system) begin
                        halted_d  = 1'b1;
                        fault_d   = 1'b0;
                        instret_d = instret_q + CNT_W'(1);
                        state_d   = S_FETCH_INSTR;
                    end else begin
                        pc_en     = 1'b1;
                        wb_en     = writes_rd;
                        instret_d = instret_q + CNT_W'(1);
                        state_d   = S_FETCH_INSTR;
                    end
                end
                S_LOAD: begin
                    mem_rstrb    = 1'b1;
                    mem_addr_sel = 1'b1;
                    state_d      = S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    mem_addr_sel = 1'b1;
                    if (!mem_rbusy) begin
                        wb_en       = 1'b1;
                        wb_sel_load = 1'b1;
                        instret_d   = instret_q + CNT_W'(1);
                        state_d     = S_FETCH_INSTR;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        halted_d = 1'b1;
                        fault_d  = 1'b1;
                        state_d  = S_FETCH_INSTR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                S_STORE: begin
                    mem_wstrb    = 1'b1;
                    mem_addr_sel = 1'b1;
                    state_d      = S_WAIT_STORE;
                end
                S_WAIT_STORE: begin
                    mem_addr_sel = 1'b1;
                    if (!mem_wbusy) begin
                        instret_d = instret_q + CNT_W'(1);
                        state_d   = S_FETCH_INSTR;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        halted_d = 1'b1;
                        fault_d  = 1'b1;
                        state_d  = S_FETCH_INSTR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                default: state_d = S_FETCH_INSTR;
            endcase
        end

        // No request or register update may escape while reset is asserted.
        if (!resetn) begin
            mem_rstrb    = 1'b0;
            mem_wstrb    = 1'b0;
            mem_addr_sel = 1'b0;
            instr_we     = 1'b0;
            regs_en      = 1'b0;
            wb_en        = 1'b0;
            wb_sel_load  = 1'b0;
            pc_en        = 1'b0;
        end
    end

    // State, flags, wait counter and retired count registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), and all
        // sequential state uses non-blocking assignments.
        if (!resetn) begin
            state_q    <= S_FETCH_INSTR;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            instret_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            instret_q  <= instret_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_rv32_step_sequencer.sv
// Testbench for rv32_step_sequencer. A small memory responder answers the
// read/write strobes with a chosen number of busy cycles; each instruction
// is summarised (cycle count, pulse counts, enable timing, retired count)
// and compared against expectations derived from the instruction class.
module tb_rv32_step_sequencer;

    localparam int MAX_WAIT = 255;
    localparam int CNT_W    = 4;   // narrow counter so wrap-around is reached
    localparam int INSTRET_MOD = 1 << CNT_W;

    logic clk = 1'b0;
    logic resetn = 1'b0, is_load = 1'b0, is_store = 1'b0, is_system = 1'b0;
    logic writes_rd = 1'b0, mem_rbusy = 1'b0, mem_wbusy = 1'b0, resume = 1'b0;
    logic mem_rstrb, mem_wstrb, mem_addr_sel, instr_we, regs_en, wb_en;
    logic wb_sel_load, pc_en, halted, fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    always #5 clk = ~clk;

    rv32_step_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .is_load(is_load), .is_store(is_store),
        .is_system(is_system), .writes_rd(writes_rd), .mem_rbusy(mem_rbusy),
        .mem_wbusy(mem_wbusy), .resume(resume), .mem_rstrb(mem_rstrb),
        .mem_wstrb(mem_wstrb), .mem_addr_sel(mem_addr_sel), .instr_we(instr_we),
        .regs_en(regs_en), .wb_en(wb_en), .wb_sel_load(wb_sel_load),
        .pc_en(pc_en), .halted(halted), .fault(fault), .state(state),
        .instret(instret)
    );

    int checks = 0, failures = 0;

    // Values driven on the next cycle.
    logic d_resetn = 1'b0, d_load = 1'b0, d_store = 1'b0, d_sys = 1'b0;
    logic d_wrd = 1'b0, d_resume = 1'b0;
    int   fetch_busy = 0, data_busy = 0, store_busy = 0;

    // Memory responder state.
    int rem_r = 0, rem_w = 0;
    bit pend_r = 0, pend_w = 0, pend_sel = 0;

    // Samples taken mid-cycle.
    logic s_rstrb, s_wstrb, s_sel, s_iwe, s_regs, s_wb, s_wsl, s_pc, s_halt, s_fault;
    logic [2:0] s_state;
    int s_instret;

    int exp_instret = 0;

    // Per-instruction tallies.
    int c_rs, c_ws, c_iwe, c_regs, c_wb, c_wsl, c_pc, c_rs_ld, c_ws_bad;
    int c_pc_cyc, c_wb_cyc;

    // One clock: drive inputs just after the rising edge, sample at the
    // falling edge, then let the memory responder react.
    task automatic step();
        @(posedge clk);
        #1;
        if (pend_r) begin rem_r = pend_sel ? data_busy : fetch_busy; pend_r = 0; end
        if (pend_w) begin rem_w = store_busy; pend_w = 0; end
        resetn = d_resetn; is_load = d_load; is_store = d_store;
        is_system = d_sys; writes_rd = d_wrd; resume = d_resume;
        mem_rbusy = (rem_r > 0); mem_wbusy = (rem_w > 0);
        @(negedge clk);
        s_rstrb = mem_rstrb; s_wstrb = mem_wstrb; s_sel = mem_addr_sel;
        s_iwe = instr_we; s_regs = regs_en; s_wb = wb_en; s_wsl = wb_sel_load;
        s_pc = pc_en; s_halt = halted; s_fault = fault; s_state = state;
        s_instret = int'(instret);
        if (mem_rbusy) rem_r--;
        if (mem_wbusy) rem_w--;
        if (mem_rstrb) begin pend_r = 1; pend_sel = mem_addr_sel; end
        if (mem_wstrb) pend_w = 1;
    endtask

    task automatic accum(input int cyc);
        c_rs  += int'(s_rstrb); c_ws  += int'(s_wstrb); c_iwe += int'(s_iwe);
        c_regs += int'(s_regs); c_wb  += int'(s_wb);    c_wsl += int'(s_wsl);
        c_pc  += int'(s_pc);
        c_rs_ld  += int'(s_rstrb && s_sel);
        c_ws_bad += int'(s_wstrb && !s_sel);
        if (s_pc) c_pc_cyc = cyc;
        if (s_wb) c_wb_cyc = cyc;
    endtask

    // Run one instruction starting from the sampled FETCH cycle and compare
    // its summary against the class-level expectation.
    task automatic run_instr(input string name, input bit ld, input bit st,
                             input bit sy, input bit wr, input int fb,
                             input int db, input int sb);
        int e_cyc, e_rs, e_ws, e_iwe, e_regs, e_pc, e_wb, e_wsl, e_inc, e_rs_ld;
        int e_pc_cyc, e_wb_cyc, cyc;
        bit e_halt, e_fault, done;
        d_load = ld; d_store = st; d_sys = sy; d_wrd = wr;
        fetch_busy = fb; data_busy = db; store_busy = sb;

        e_rs = 1; e_ws = 0; e_iwe = 1; e_regs = 1; e_pc = 1; e_wb = 0; e_wsl = 0;
        e_inc = 1; e_rs_ld = 0; e_halt = 0; e_fault = 0;
        e_pc_cyc = 4 + fb; e_wb_cyc = 4 + fb; e_cyc = 4 + fb;
        if (fb >= MAX_WAIT) begin
            e_cyc = 1 + MAX_WAIT; e_iwe = 0; e_regs = 0; e_pc = 0; e_inc = 0;
            e_halt = 1; e_fault = 1;
        end else if (ld) begin
            e_cyc = 6 + fb + db; e_rs = 2; e_rs_ld = 1; e_wb = 1; e_wsl = 1;
            e_wb_cyc = e_cyc;
        end else if (st) begin
            e_cyc = 6 + fb + sb; e_ws = 1;
        end else if (sy) begin
            e_pc = 0; e_halt = 1;
        end else begin
            e_wb = wr ? 1 : 0;
        end
        exp_instret = (exp_instret + e_inc) % INSTRET_MOD;

        c_rs = 0; c_ws = 0; c_iwe = 0; c_regs = 0; c_wb = 0; c_wsl = 0; c_pc = 0;
        c_rs_ld = 0; c_ws_bad = 0; c_pc_cyc = -1; c_wb_cyc = -1;
        accum(1);
        cyc = 1; done = 0;
        while (!done && cyc < 2000) begin
            step();
            if (s_state == 3'd0) done = 1;
            else begin cyc++; accum(cyc); end
        end

        checks++; if (cyc !== e_cyc) begin failures++; $display("FAIL %s cycles got=%0d exp=%0d", name, cyc, e_cyc); end
        checks++; if (c_rs !== e_rs) begin failures++; $display("FAIL %s rstrb_count got=%0d exp=%0d", name, c_rs, e_rs); end
        checks++; if (c_ws !== e_ws) begin failures++; $display("FAIL %s wstrb_count got=%0d exp=%0d", name, c_ws, e_ws); end
        checks++; if (c_iwe !== e_iwe) begin failures++; $display("FAIL %s instr_we_count got=%0d exp=%0d", name, c_iwe, e_iwe); end
        checks++; if (c_regs !== e_regs) begin failures++; $display("FAIL %s regs_en_count got=%0d exp=%0d", name, c_regs, e_regs); end
        checks++; if (c_pc !== e_pc) begin failures++; $display("FAIL %s pc_en_count got=%0d exp=%0d", name, c_pc, e_pc); end
        checks++; if (c_wb !== e_wb) begin failures++; $display("FAIL %s wb_en_count got=%0d exp=%0d", name, c_wb, e_wb); end
        checks++; if (c_wsl !== e_wsl) begin failures++; $display("FAIL %s wb_sel_load_count got=%0d exp=%0d", name, c_wsl, e_wsl); end
        checks++; if (c_rs_ld !== e_rs_ld) begin failures++; $display("FAIL %s rstrb_addr_sel1 got=%0d exp=%0d", name, c_rs_ld, e_rs_ld); end
        checks++; if (c_ws_bad !== 0) begin failures++; $display("FAIL %s wstrb_addr_sel0 got=%0d exp=0", name, c_ws_bad); end
        if (e_pc > 0) begin
            checks++; if (c_pc_cyc !== e_pc_cyc) begin failures++; $display("FAIL %s pc_en_cycle got=%0d exp=%0d", name, c_pc_cyc, e_pc_cyc); end
        end
        if (e_wb > 0) begin
            checks++; if (c_wb_cyc !== e_wb_cyc) begin failures++; $display("FAIL %s wb_en_cycle got=%0d exp=%0d", name, c_wb_cyc, e_wb_cyc); end
        end
        checks++; if (s_instret !== exp_instret) begin failures++; $display("FAIL %s instret got=%0d exp=%0d", name, s_instret, exp_instret); end
        checks++; if (s_halt !== e_halt) begin failures++; $display("FAIL %s halted got=%0b exp=%0b", name, s_halt, e_halt); end
        checks++; if (s_fault !== e_fault) begin failures++; $display("FAIL %s fault got=%0b exp=%0b", name, s_fault, e_fault); end
    endtask

    // Hold in HALT for a few cycles, then pulse resume and land on FETCH.
    task automatic do_resume(input string name);
        int frozen;
        frozen = 0;
        d_resume = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            frozen += int'(s_pc) + int'(s_rstrb) + int'(!s_halt);
        end
        checks++; if (frozen !== 0) begin failures++; $display("FAIL %s halt_frozen got=%0d exp=0", name, frozen); end
        d_resume = 1'b1;
        step();
        checks++; if (s_pc !== 1'b1) begin failures++; $display("FAIL %s resume_pc_en got=%0b exp=1", name, s_pc); end
        d_resume = 1'b0;
        step();
        checks++; if ({s_state, s_halt, s_fault, s_rstrb} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL %s after_resume state=%0d halted=%0b fault=%0b rstrb=%0b exp 0/0/0/1",
                                 name, s_state, s_halt, s_fault, s_rstrb);
        end
    endtask

    task automatic test_reset();
        d_resetn = 1'b0;
        step(); step();
        checks++; if ({s_state, s_halt, s_fault} !== {3'd0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset_state state=%0d halted=%0b fault=%0b exp 0/0/0", s_state, s_halt, s_fault);
        end
        checks++; if (s_instret !== 0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", s_instret); end
        checks++; if ({s_rstrb, s_wstrb, s_pc, s_wb} !== 4'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=0000", {s_rstrb, s_wstrb, s_pc, s_wb});
        end
        d_resetn = 1'b1;
        step();
        checks++; if ({s_state, s_rstrb} !== {3'd0, 1'b1}) begin
            failures++; $display("FAIL reset_first_fetch state=%0d rstrb=%0b exp 0/1", s_state, s_rstrb);
        end
        exp_instret = 0;
    endtask

    task automatic test_alu();
        run_instr("addi", 0, 0, 0, 1, 0, 0, 0);
        run_instr("alu_nowb", 0, 0, 0, 0, 2, 0, 0);
    endtask

    task automatic test_load_wait();
        run_instr("lw_busy3", 1, 0, 0, 1, 0, 3, 0);
    endtask

    task automatic test_store();
        run_instr("sw", 0, 1, 0, 1, 0, 0, 0);
        run_instr("sw_busy2", 0, 1, 0, 0, 1, 0, 2);
    endtask

    task automatic test_ebreak();
        run_instr("ebreak", 0, 0, 1, 1, 0, 0, 0);
        do_resume("ebreak");
    endtask

    task automatic test_priority();
        run_instr("prio_all", 1, 1, 1, 1, 0, 1, 0);
        run_instr("prio_st_sys", 0, 1, 1, 1, 0, 0, 1);
    endtask

    task automatic test_timeout();
        run_instr("wait_254", 0, 0, 0, 1, MAX_WAIT - 1, 0, 0);
        run_instr("timeout", 0, 0, 0, 1, 400, 0, 0);
        rem_r = 0;
        do_resume("timeout");
    endtask

    task automatic test_reset_mid();
        int n;
        d_load = 1; d_store = 0; d_sys = 0; d_wrd = 1;
        fetch_busy = 0; data_busy = 10;
        n = 0;
        while (s_state !== 3'd5 && n < 50) begin step(); n++; end
        checks++; if (s_state !== 3'd5) begin failures++; $display("FAIL rst_mid_reach_wait_data got=%0d exp=5", s_state); end
        step();
        d_resetn = 1'b0;
        step();
        checks++; if ({s_wb, s_rstrb, s_sel} !== 3'b000) begin
            failures++; $display("FAIL rst_mid_forced got=%b exp=000", {s_wb, s_rstrb, s_sel});
        end
        step();
        checks++; if ({s_state, s_instret, s_wb} !== {3'd0, 32'd0, 1'b0}) begin
            failures++; $display("FAIL rst_mid_after state=%0d instret=%0d wb_en=%0b exp 0/0/0", s_state, s_instret, s_wb);
        end
        rem_r = 0; rem_w = 0; pend_r = 0; pend_w = 0; exp_instret = 0;
        d_resetn = 1'b1;
        step();
        checks++; if ({s_state, s_rstrb} !== {3'd0, 1'b1}) begin
            failures++; $display("FAIL rst_mid_refetch state=%0d rstrb=%0b exp 0/1", s_state, s_rstrb);
        end
    endtask

    task automatic test_random();
        bit ld, st, sy, wr;
        for (int i = 0; i < 60; i++) begin
            ld = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) == 0);
            sy = ($urandom_range(0, 7) == 0);
            wr = $urandom_range(0, 1) == 1;
            run_instr($sformatf("rand%0d", i), ld, st, sy, wr,
                      $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4));
            if (!ld && !st && sy) do_resume($sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_store();
        test_ebreak();
        test_priority();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
